// File: rtl/accumulate.sv
// Dot-product accumulator: sums up to N signed 2W-bit products per frame and
// emits one registered result per frame. Define ACCUMULATE_SATURATE_EN to clamp results instead of wrapping.
module accumulate #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_stb,
  input  logic [2*W-1:0] s_dat,
  input  logic           s_lst,
  output logic           s_rdy,
  input  logic           m_rdy,
  output logic           m_stb,
  output logic [2*W-1:0] m_dat
);

  localparam int G  = $clog2(N) + 1;
  localparam int AW = 2*W + G;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic [CW-1:0]        cnt;
  logic                 take;
  logic                 last;
  logic [2*W-1:0]       res;

  assign s_rdy = ~m_stb | m_rdy;
  assign take  = s_stb & s_rdy;
  assign last  = s_lst | (cnt == CNT_LAST);

  always_comb begin
    sum = acc + {{G{s_dat[2*W-1]}}, s_dat};
  end

`ifdef ACCUMULATE_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(G+1){1'b0}}, {(2*W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(G+1){1'b1}}, {(2*W-1){1'b0}}};

  always_comb begin
    res = sum[2*W-1:0];
    if (sum > SAT_MAX)
      res = {1'b0, {(2*W-1){1'b1}}};
    else if (sum < SAT_MIN)
      res = {1'b1, {(2*W-1){1'b0}}};
  end
`else
  always_comb begin
    res = sum[2*W-1:0];
  end
`endif

  // A result loading in the same cycle as an output transfer keeps m_stb high.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      m_stb <= 1'b0;
      m_dat <= '0;
    end else begin
      if (m_stb & m_rdy)
        m_stb <= 1'b0;
      if (take) begin
        if (last) begin
          m_dat <= res;
          m_stb <= 1'b1;
          acc   <= '0;
          cnt   <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_accumulate.sv
// Bench for accumulate (W=8, N=4): directed vector table, reset sequence and
// randomized traffic against a frame-sum reference model.
module tb_accumulate;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_stb;
  logic [15:0] s_dat;
  logic        s_lst;
  logic        s_rdy;
  logic        m_rdy;
  logic        m_stb;
  logic [15:0] m_dat;

  int n_checks = 0;
  int n_fail   = 0;

  accumulate #(.W(8), .N(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_stb(s_stb),
    .s_dat(s_dat),
    .s_lst(s_lst),
    .s_rdy(s_rdy),
    .m_rdy(m_rdy),
    .m_stb(m_stb),
    .m_dat(m_dat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stb;
    logic [15:0] dat;
    logic        lst;
    logic        rdy;
    logic        exp_srdy;
    logic        exp_stb;
    logic        chk_dat;
    logic [15:0] exp_dat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fmt(input longint x);
`ifdef ACCUMULATE_SATURATE_EN
    if (x > 32767) return 16'h7fff;
    if (x < -32768) return 16'h8000;
`endif
    return x[15:0];
  endfunction

  function automatic void add(input logic stb, input int dat, input logic lst, input logic rdy,
                              input logic esr, input logic est, input logic cd, input int ed);
    vec_t v;
    v.stb = stb; v.dat = dat[15:0]; v.lst = lst; v.rdy = rdy;
    v.exp_srdy = esr; v.exp_stb = est; v.chk_dat = cd; v.exp_dat = ed[15:0];
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic stb, input logic [15:0] dat, input logic lst, input logic rdy);
    s_stb = stb; s_dat = dat; s_lst = lst; m_rdy = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference model state for the randomized phase.
  longint    frame_sum;
  int        frame_terms;
  logic [15:0] exp_q[$];

  initial begin
    logic [15:0] pos_big, neg_big;
    logic        prev_hold;
    logic [15:0] prev_dat;
    logic        smp_stb, smp_srdy, smp_mrdy, acc_in;
    logic [15:0] smp_dat;

    pos_big = fmt(131068);
    neg_big = fmt(-131072);

    // Basic frame: 100+200-50+7 = 257, valid for exactly one cycle.
    add(1, 100, 0, 1, 1, 0, 0, 0);
    add(1, 200, 0, 1, 1, 0, 0, 0);
    add(1, -50, 0, 1, 1, 0, 0, 0);
    add(1,   7, 0, 1, 1, 1, 1, 257);
    add(0,   0, 0, 1, 1, 0, 0, 0);
    // Full-scale positive and negative frames.
    for (int i = 0; i < 4; i++) add(1, 32767, 0, 1, 1, i == 3, i == 3, int'(pos_big));
    add(0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, -32768, 0, 1, 1, i == 3, i == 3, int'(neg_big));
    add(0, 0, 0, 1, 1, 0, 0, 0);
    // Early frame end on s_lst, then a full frame proves the counter restarted.
    add(1, 3, 0, 1, 1, 0, 0, 0);
    add(1, 4, 1, 1, 1, 1, 1, 7);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1, 1, 4);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    // Backpressure: result 20 held five cycles with a last-beat offered and refused.
    for (int i = 0; i < 4; i++) add(1, 5, 0, 0, 1, i == 3, i == 3, 20);
    for (int i = 0; i < 5; i++) add(1, 7, 1, 0, 0, 1, 1, 20);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 2, 0, 1, 1, 0, 0, 0);
    add(1, 3, 0, 1, 1, 0, 0, 0);
    add(1, 4, 0, 1, 1, 1, 1, 10);
    // Single-term frame reloads while 10 leaves: no gap cycle.
    add(1, 9, 1, 1, 1, 1, 1, 9);
    add(0, 0, 0, 1, 1, 0, 0, 0);

    do_reset();
    do_reset();
    check("reset_m_stb", 32'(m_stb), 0);
    check("reset_m_dat", 32'(m_dat), 0);
    check("reset_s_rdy", 32'(s_rdy), 1);

    foreach (vecs[i]) begin
      drive(vecs[i].stb, vecs[i].dat, vecs[i].lst, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("vec%0d_s_rdy", i), 32'(s_rdy), 32'(vecs[i].exp_srdy));
      @(posedge clk); #1;
      check($sformatf("vec%0d_m_stb", i), 32'(m_stb), 32'(vecs[i].exp_stb));
      if (vecs[i].chk_dat)
        check($sformatf("vec%0d_m_dat", i), 32'(m_dat), 32'(vecs[i].exp_dat));
    end

    // Reset while a result is pending.
    drive(1, 16'd3, 1, 0);
    @(posedge clk); #1;
    check("pend_m_stb", 32'(m_stb), 1);
    do_reset();
    check("rst_pend_m_stb", 32'(m_stb), 0);
    check("rst_pend_m_dat", 32'(m_dat), 0);
    check("rst_pend_s_rdy", 32'(s_rdy), 1);
    // Reset mid-frame: 5 and 6 are discarded.
    drive(1, 16'd5, 0, 1); @(posedge clk); #1;
    drive(1, 16'd6, 0, 1); @(posedge clk); #1;
    do_reset();
    check("rst_mid_m_stb", 32'(m_stb), 0);
    check("rst_mid_m_dat", 32'(m_dat), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'd1, 0, 1); @(posedge clk); #1;
    end
    check("rst_mid_res_stb", 32'(m_stb), 1);
    check("rst_mid_res_dat", 32'(m_dat), 4);

    // Randomized traffic against the frame-sum model.
    do_reset();
    frame_sum = 0; frame_terms = 0; prev_hold = 1'b0; prev_dat = '0;
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] d;
      int sel;
      sel = $urandom_range(0, 9);
      d = (sel == 0) ? 16'h7fff : (sel == 1) ? 16'h8000 : 16'($urandom);
      if (c >= 2980) drive(0, 16'h0, 0, 1);
      else drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
      @(negedge clk);
      smp_stb = m_stb; smp_dat = m_dat; smp_srdy = s_rdy; smp_mrdy = m_rdy;
      acc_in = s_stb & s_rdy;
      check("rnd_s_rdy", 32'(smp_srdy), 32'(!smp_stb || smp_mrdy));
      if (prev_hold) begin
        check("rnd_hold_stb", 32'(smp_stb), 1);
        check("rnd_hold_dat", 32'(smp_dat), 32'(prev_dat));
      end
      if (smp_stb && smp_mrdy) begin
        if (exp_q.size() == 0) check("rnd_unexpected_result", 32'(smp_dat), 32'hffffffff);
        else check("rnd_result", 32'(smp_dat), 32'(exp_q.pop_front()));
      end
      if (acc_in) begin
        frame_sum += longint'($signed(s_dat));
        frame_terms++;
        if (frame_terms == 4 || s_lst) begin
          exp_q.push_back(fmt(frame_sum));
          frame_sum = 0;
          frame_terms = 0;
        end
      end
      prev_hold = smp_stb && !smp_mrdy;
      prev_dat = smp_dat;
      @(posedge clk); #1;
    end
    check("rnd_drain_empty", 32'(exp_q.size()), 0);
    check("rnd_drain_m_stb", 32'(m_stb), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
